// File: rtl/config_loader_if.sv
// config_loader_if
//   Groups the bitstream handshake and chain-side signals of config_loader.
//   Clock and reset stay plain ports on the module.
//   master : bitstream source / host (drives start, word_valid, word_data)
//   slave  : config_loader (drives word_ready, config_out, chain_shift_en,
//            busy, done, bit_count)
interface config_loader_if #(
  parameter int CHAIN_LEN = 32,
  parameter int WORD_W    = 8
);
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  logic              start;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;
  logic              config_out;
  logic              chain_shift_en;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  bit_count;

  modport master (
    output start, word_valid, word_data,
    input  word_ready, config_out, chain_shift_en, busy, done, bit_count
  );

  modport slave (
    input  start, word_valid, word_data,
    output word_ready, config_out, chain_shift_en, busy, done, bit_count
  );
endinterface

// File: rtl/config_loader.sv
// config_loader
//   Transmitter end of the serial configuration chain. Accepts WORD_W-bit
//   words over a valid/ready handshake and shifts them LSB first onto the
//   chain head, qualifying every real shift with chain_shift_en. Exactly
//   CHAIN_LEN bits are shifted per load; surplus bits of the last word are
//   dropped and no extra word is requested.
//   Ports:
//     config_clk   : clock shared with the chain
//     config_reset : synchronous, active-high reset
//     bus          : config_loader_if.slave (start, word_valid/word_data/
//                    word_ready handshake, config_out, chain_shift_en,
//                    busy, done, bit_count)
module config_loader #(
  parameter int CHAIN_LEN = 32,
  parameter int WORD_W    = 8
) (
  input  logic            config_clk,
  input  logic            config_reset,
  config_loader_if.slave  bus
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BL_W  = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] hreg_q, hreg_d;
  logic [BL_W-1:0]   bits_left_q, bits_left_d;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d;

  logic shifting;
  logic word_ready;
  logic transfer;
  logic last_bit;

  // A bit is on the wire whenever LOAD holds buffered bits. A new word is
  // accepted when the buffer is empty or about to empty, but only while the
  // chain still needs more bits than are already buffered.
  always_comb begin
    shifting   = (state_q == LOAD) && (bits_left_q != '0);
    word_ready = (state_q == LOAD) && (bits_left_q <= BL_W'(1)) &&
                 ((int'(bit_count_q) + int'(bits_left_q)) < CHAIN_LEN);
    transfer   = word_ready && bus.word_valid;
    last_bit   = shifting && (int'(bit_count_q) == CHAIN_LEN - 1);
  end

  always_comb begin
    state_d     = state_q;
    hreg_d      = hreg_q;
    bits_left_d = bits_left_q;
    bit_count_d = bit_count_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = LOAD;
          hreg_d      = '0;
          bits_left_d = '0;
          bit_count_d = '0;
        end
      end
      LOAD: begin
        if (shifting) begin
          hreg_d      = hreg_q >> 1;
          bits_left_d = bits_left_q - BL_W'(1);
          bit_count_d = bit_count_q + CNT_W'(1);
        end
        // A word landing on the same edge as the last buffered bit replaces
        // the drained buffer, giving gap-free streaming.
        if (transfer) begin
          hreg_d      = bus.word_data;
          bits_left_d = BL_W'(WORD_W);
        end
        // The final chain bit discards whatever is left of the current word.
        if (last_bit) begin
          state_d     = DONE;
          hreg_d      = '0;
          bits_left_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge config_clk) begin
    if (config_reset) begin
      state_q     <= IDLE;
      hreg_q      <= '0;
      bits_left_q <= '0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hreg_q      <= hreg_d;
      bits_left_q <= bits_left_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign bus.word_ready     = word_ready;
  assign bus.config_out     = shifting & hreg_q[0];
  assign bus.chain_shift_en = shifting;
  assign bus.busy           = (state_q == LOAD);
  assign bus.done           = (state_q == DONE);
  assign bus.bit_count      = bit_count_q;

endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader
//   Two loaders: dut_a (CHAIN_LEN=16, WORD_W=8) and dut_b (CHAIN_LEN=10,
//   WORD_W=4). Expected serial bits are queued as words are offered to the
//   source and compared with the bits captured on shifting cycles.
module tb_config_loader;
  localparam int A_LEN = 16;
  localparam int A_W   = 8;
  localparam int B_LEN = 10;
  localparam int B_W   = 4;

  logic config_clk = 1'b0;
  logic config_reset;

  always #5 config_clk = ~config_clk;

  config_loader_if #(.CHAIN_LEN(A_LEN), .WORD_W(A_W)) bus_a();
  config_loader_if #(.CHAIN_LEN(B_LEN), .WORD_W(B_W)) bus_b();

  config_loader #(.CHAIN_LEN(A_LEN), .WORD_W(A_W)) dut_a (
    .config_clk   (config_clk),
    .config_reset (config_reset),
    .bus          (bus_a)
  );

  config_loader #(.CHAIN_LEN(B_LEN), .WORD_W(B_W)) dut_b (
    .config_clk   (config_clk),
    .config_reset (config_reset),
    .bus          (bus_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cycle  = 0;

  logic [A_W-1:0] src_a[$];
  bit             exp_a[$];
  bit             obs_a[$];
  bit             src_en_a;
  int             xfer_a, shifts_a, first_sh_a, last_sh_a, queued_a;

  logic [B_W-1:0] src_b[$];
  bit             exp_b[$];
  bit             obs_b[$];
  bit             src_en_b;
  int             xfer_b, shifts_b, first_sh_b, last_sh_b, queued_b;

  // One clock: note transfers due at the edge, capture shifted bits after
  // it, then present the next source word (filler 1s once a queue is empty).
  task automatic tick();
    bit xa, xb;
    xa = bus_a.word_valid && bus_a.word_ready;
    xb = bus_b.word_valid && bus_b.word_ready;
    @(posedge config_clk);
    #1;
    cycle++;
    if (xa) begin
      xfer_a++;
      if (src_a.size() > 0) void'(src_a.pop_front());
    end
    if (xb) begin
      xfer_b++;
      if (src_b.size() > 0) void'(src_b.pop_front());
    end
    if (bus_a.chain_shift_en) begin
      if (shifts_a == 0) first_sh_a = cycle;
      last_sh_a = cycle;
      shifts_a++;
      obs_a.push_back(bus_a.config_out);
    end
    if (bus_b.chain_shift_en) begin
      if (shifts_b == 0) first_sh_b = cycle;
      last_sh_b = cycle;
      shifts_b++;
      obs_b.push_back(bus_b.config_out);
    end
    bus_a.word_valid = src_en_a;
    bus_a.word_data  = (src_a.size() > 0) ? src_a[0] : '1;
    bus_b.word_valid = src_en_b;
    bus_b.word_data  = (src_b.size() > 0) ? src_b[0] : '1;
  endtask

  task automatic clear_a();
    src_a.delete(); exp_a.delete(); obs_a.delete();
    xfer_a = 0; shifts_a = 0; first_sh_a = -1; last_sh_a = -1; queued_a = 0;
  endtask

  task automatic clear_b();
    src_b.delete(); exp_b.delete(); obs_b.delete();
    xfer_b = 0; shifts_b = 0; first_sh_b = -1; last_sh_b = -1; queued_b = 0;
  endtask

  // Offer a word and predict its bits, LSB first, up to the chain length.
  task automatic queue_word_a(input logic [A_W-1:0] w);
    src_a.push_back(w);
    for (int i = 0; i < A_W; i++)
      if (queued_a < A_LEN) begin exp_a.push_back(w[i]); queued_a++; end
  endtask

  task automatic queue_word_b(input logic [B_W-1:0] w);
    src_b.push_back(w);
    for (int i = 0; i < B_W; i++)
      if (queued_b < B_LEN) begin exp_b.push_back(w[i]); queued_b++; end
  endtask

  task automatic start_a();
    bus_a.start = 1'b1; tick(); bus_a.start = 1'b0;
  endtask

  task automatic start_b();
    bus_b.start = 1'b1; tick(); bus_b.start = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus_a.done === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    if (bus_a.done === 1'b1) ok = 1'b1;
  endtask

  task automatic wait_done_b(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus_b.done === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    if (bus_b.done === 1'b1) ok = 1'b1;
  endtask

  task automatic test_reset();
    int bad_a, bad_b;
    config_reset = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({bus_a.word_ready, bus_a.config_out, bus_a.chain_shift_en, bus_a.busy, bus_a.done} !== 5'b0) begin
      n_fail++; $display("[TB] FAIL reset_outputs_a: got %b want 00000",
        {bus_a.word_ready, bus_a.config_out, bus_a.chain_shift_en, bus_a.busy, bus_a.done});
    end
    n_cmp++;
    if (bus_a.bit_count !== '0) begin
      n_fail++; $display("[TB] FAIL reset_bit_count_a: got %0d want 0", bus_a.bit_count);
    end
    n_cmp++;
    if ({bus_b.word_ready, bus_b.config_out, bus_b.chain_shift_en, bus_b.busy, bus_b.done, bus_b.bit_count} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_outputs_b: got nonzero outputs want all 0");
    end
    config_reset = 1'b0;
    src_en_a = 1'b1;
    src_en_b = 1'b1;
    bad_a = 0;
    bad_b = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_a.word_ready !== 1'b0 || bus_a.chain_shift_en !== 1'b0 || bus_a.done !== 1'b0) bad_a++;
      if (bus_b.word_ready !== 1'b0 || bus_b.chain_shift_en !== 1'b0 || bus_b.done !== 1'b0) bad_b++;
    end
    n_cmp++;
    if (bad_a !== 0) begin n_fail++; $display("[TB] FAIL idle_quiet_a: got %0d active cycles want 0", bad_a); end
    n_cmp++;
    if (bad_b !== 0) begin n_fail++; $display("[TB] FAIL idle_quiet_b: got %0d active cycles want 0", bad_b); end
    src_en_a = 1'b0;
    src_en_b = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok, e, o;
    int cs;
    clear_a();
    queue_word_a(8'hA5);
    queue_word_a(8'h3C);
    src_en_a = 1'b1;
    cs = cycle;
    start_a();
    wait_done_a(60, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_done: got %0b want 1", ok); end
    n_cmp++;
    if (first_sh_a !== cs + 2) begin n_fail++; $display("[TB] FAIL b2b_latency: first shift cycle %0d want %0d", first_sh_a, cs + 2); end
    n_cmp++;
    if (shifts_a !== 16 || last_sh_a - first_sh_a + 1 !== 16) begin
      n_fail++; $display("[TB] FAIL b2b_contiguous: got %0d shifts over %0d cycles want 16/16", shifts_a, last_sh_a - first_sh_a + 1);
    end
    repeat (5) tick();
    n_cmp++;
    if (int'(bus_a.bit_count) !== 16) begin n_fail++; $display("[TB] FAIL b2b_bit_count: got %0d want 16", bus_a.bit_count); end
    n_cmp++;
    if (xfer_a !== 2) begin n_fail++; $display("[TB] FAIL b2b_words: got %0d want 2", xfer_a); end
    n_cmp++;
    if (bus_a.chain_shift_en !== 1'b0 || bus_a.done !== 1'b1) begin
      n_fail++; $display("[TB] FAIL b2b_done_state: got shift_en=%0b done=%0b want 0/1", bus_a.chain_shift_en, bus_a.done);
    end
    n_cmp++;
    if (obs_a.size() !== exp_a.size()) begin n_fail++; $display("[TB] FAIL b2b_bit_total: got %0d want %0d", obs_a.size(), exp_a.size()); end
    for (int i = 0; exp_a.size() > 0 && obs_a.size() > 0; i++) begin
      e = exp_a.pop_front(); o = obs_a.pop_front();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("[TB] FAIL b2b_bit%0d: got %0b want %0b", i, o, e); end
    end
    src_en_a = 1'b0;
  endtask

  task automatic test_partial_word();
    bit ok, e, o;
    clear_b();
    queue_word_b(4'hF);
    queue_word_b(4'h0);
    queue_word_b(4'h9);
    src_en_b = 1'b1;
    start_b();
    wait_done_b(60, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL partial_done: got %0b want 1", ok); end
    repeat (5) tick();
    n_cmp++;
    if (shifts_b !== 10 || last_sh_b - first_sh_b + 1 !== 10) begin
      n_fail++; $display("[TB] FAIL partial_shifts: got %0d shifts want 10", shifts_b);
    end
    n_cmp++;
    if (xfer_b !== 3) begin n_fail++; $display("[TB] FAIL partial_words: got %0d want 3", xfer_b); end
    n_cmp++;
    if (int'(bus_b.bit_count) !== 10) begin n_fail++; $display("[TB] FAIL partial_bit_count: got %0d want 10", bus_b.bit_count); end
    n_cmp++;
    if (obs_b.size() !== exp_b.size()) begin n_fail++; $display("[TB] FAIL partial_bit_total: got %0d want %0d", obs_b.size(), exp_b.size()); end
    for (int i = 0; exp_b.size() > 0 && obs_b.size() > 0; i++) begin
      e = exp_b.pop_front(); o = obs_b.pop_front();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("[TB] FAIL partial_bit%0d: got %0b want %0b", i, o, e); end
    end
    src_en_b = 1'b0;
  endtask

  task automatic test_source_stall();
    bit ok, e, o;
    int guard;
    clear_a();
    queue_word_a(8'hA5);
    src_en_a = 1'b1;
    start_a();
    guard = 0;
    while (xfer_a < 1 && guard < 20) begin tick(); guard++; end
    src_en_a = 1'b0;
    while (shifts_a < 8 && guard < 40) begin tick(); guard++; end
    n_cmp++;
    if (shifts_a !== 8) begin n_fail++; $display("[TB] FAIL stall_first_word: got %0d shifts want 8", shifts_a); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (bus_a.chain_shift_en !== 1'b0 || bus_a.config_out !== 1'b0) begin
        n_fail++; $display("[TB] FAIL stall_idle_c%0d: got shift_en=%0b out=%0b want 0/0", i, bus_a.chain_shift_en, bus_a.config_out);
      end
      n_cmp++;
      if (int'(bus_a.bit_count) !== 8) begin n_fail++; $display("[TB] FAIL stall_count_c%0d: got %0d want 8", i, bus_a.bit_count); end
    end
    queue_word_a(8'h3C);
    src_en_a = 1'b1;
    wait_done_a(60, ok);
    n_cmp++;
    if (ok !== 1'b1 || int'(bus_a.bit_count) !== 16) begin
      n_fail++; $display("[TB] FAIL stall_resume: got done=%0b count=%0d want 1/16", ok, bus_a.bit_count);
    end
    n_cmp++;
    if (obs_a.size() !== exp_a.size()) begin n_fail++; $display("[TB] FAIL stall_bit_total: got %0d want %0d", obs_a.size(), exp_a.size()); end
    for (int i = 0; exp_a.size() > 0 && obs_a.size() > 0; i++) begin
      e = exp_a.pop_front(); o = obs_a.pop_front();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("[TB] FAIL stall_bit%0d: got %0b want %0b", i, o, e); end
    end
    src_en_a = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    bit ok, e, o;
    int guard;
    clear_a();
    queue_word_a(8'hA5);
    queue_word_a(8'h3C);
    src_en_a = 1'b1;
    start_a();
    guard = 0;
    while (shifts_a < 5 && guard < 30) begin tick(); guard++; end
    config_reset = 1'b1;
    tick();
    config_reset = 1'b0;
    n_cmp++;
    if (bus_a.busy !== 1'b0 || bus_a.chain_shift_en !== 1'b0 || bus_a.done !== 1'b0 || bus_a.word_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL midreset_outputs: got busy=%0b shift_en=%0b done=%0b ready=%0b want 0",
        bus_a.busy, bus_a.chain_shift_en, bus_a.done, bus_a.word_ready);
    end
    n_cmp++;
    if (bus_a.bit_count !== '0) begin n_fail++; $display("[TB] FAIL midreset_count: got %0d want 0", bus_a.bit_count); end
    clear_a();
    queue_word_a(8'h96);
    queue_word_a(8'h0F);
    start_a();
    wait_done_a(60, ok);
    n_cmp++;
    if (ok !== 1'b1 || int'(bus_a.bit_count) !== 16 || xfer_a !== 2) begin
      n_fail++; $display("[TB] FAIL midreset_reload: got done=%0b count=%0d words=%0d want 1/16/2", ok, bus_a.bit_count, xfer_a);
    end
    for (int i = 0; exp_a.size() > 0 && obs_a.size() > 0; i++) begin
      e = exp_a.pop_front(); o = obs_a.pop_front();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("[TB] FAIL midreset_bit%0d: got %0b want %0b", i, o, e); end
    end
    src_en_a = 1'b0;
  endtask

  task automatic test_restart_from_done();
    bit ok, e, o;
    n_cmp++;
    if (bus_a.done !== 1'b1) begin n_fail++; $display("[TB] FAIL restart_pre_done: got %0b want 1", bus_a.done); end
    clear_a();
    queue_word_a(8'h5A);
    queue_word_a(8'hC3);
    src_en_a = 1'b1;
    start_a();
    n_cmp++;
    if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b1 || bus_a.bit_count !== '0) begin
      n_fail++; $display("[TB] FAIL restart_clear: got done=%0b busy=%0b count=%0d want 0/1/0", bus_a.done, bus_a.busy, bus_a.bit_count);
    end
    wait_done_a(60, ok);
    n_cmp++;
    if (ok !== 1'b1 || int'(bus_a.bit_count) !== 16) begin
      n_fail++; $display("[TB] FAIL restart_complete: got done=%0b count=%0d want 1/16", ok, bus_a.bit_count);
    end
    n_cmp++;
    if (obs_a.size() !== exp_a.size()) begin n_fail++; $display("[TB] FAIL restart_bit_total: got %0d want %0d", obs_a.size(), exp_a.size()); end
    for (int i = 0; exp_a.size() > 0 && obs_a.size() > 0; i++) begin
      e = exp_a.pop_front(); o = obs_a.pop_front();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("[TB] FAIL restart_bit%0d: got %0b want %0b", i, o, e); end
    end
    src_en_a = 1'b0;
  endtask

  task automatic test_start_during_load();
    bit ok, e, o;
    int guard, bc;
    clear_a();
    queue_word_a(8'h3C);
    queue_word_a(8'hA5);
    src_en_a = 1'b1;
    start_a();
    guard = 0;
    while (shifts_a < 6 && guard < 30) begin tick(); guard++; end
    bc = int'(bus_a.bit_count);
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    n_cmp++;
    if (int'(bus_a.bit_count) !== bc + 1 || bus_a.busy !== 1'b1) begin
      n_fail++; $display("[TB] FAIL midstart_count: got count=%0d busy=%0b want %0d/1", bus_a.bit_count, bus_a.busy, bc + 1);
    end
    wait_done_a(60, ok);
    repeat (3) tick();
    n_cmp++;
    if (ok !== 1'b1 || shifts_a !== 16 || xfer_a !== 2) begin
      n_fail++; $display("[TB] FAIL midstart_complete: got done=%0b shifts=%0d words=%0d want 1/16/2", ok, shifts_a, xfer_a);
    end
    for (int i = 0; exp_a.size() > 0 && obs_a.size() > 0; i++) begin
      e = exp_a.pop_front(); o = obs_a.pop_front();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("[TB] FAIL midstart_bit%0d: got %0b want %0b", i, o, e); end
    end
    src_en_a = 1'b0;
  endtask

  initial begin
    config_reset     = 1'b1;
    bus_a.start      = 1'b0;
    bus_a.word_valid = 1'b0;
    bus_a.word_data  = '0;
    bus_b.start      = 1'b0;
    bus_b.word_valid = 1'b0;
    bus_b.word_data  = '0;
    src_en_a = 1'b0;
    src_en_b = 1'b0;
    clear_a();
    clear_b();
    test_reset();
    test_back_to_back();
    test_partial_word();
    test_source_stall();
    test_reset_mid_load();
    test_restart_from_done();
    test_start_during_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] simulation time limit reached");
  end
endmodule
